// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the FIFO-fed UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } uart_tx_state_t;

    // Serial bit periods in one frame: start + data + optional parity + stop bits.
    function automatic int frame_bits(input int data_width, input int parity_en, input int stop_bits);
        return 1 + data_width + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - free-running bit-period tick generator with synchronous clear
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick,
    output logic pre_tick
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] PRE_TICK  = TW'(CLKS_PER_BIT - 2);

    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;

    // Count 0..CLKS_PER_BIT-1 and wrap on the last cycle of each bit period.
    always_comb begin
        tick_d = tick_q;
        if (clear || (tick_q == LAST_TICK)) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + 1'b1;
        end
    end

    // Tick counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    // pre_tick lets the owner register a strobe that lands on the bit's last cycle.
    assign bit_tick = !clear && (tick_q == LAST_TICK);
    assign pre_tick = !clear && (tick_q == PRE_TICK);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from a FIFO and serialises them as UART frames
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    input  logic                  tx_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    uart_tx_state_t          state_q, state_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    parity_q, parity_d;
    logic                    tx_q, tx_d;
    logic                    rd_en_q, rd_en_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;
    logic                    bit_tick;
    logic                    pre_tick;
    logic                    timer_clear;
    logic                    last_data;
    logic                    last_stop;

    // The timer idles at zero until the start bit so every bit is exactly one period.
    assign timer_clear = (state_q == ST_IDLE) || (state_q == ST_POP) || (state_q == ST_LOAD);
    assign last_data   = (bit_cnt_q == LAST_DATA);
    assign last_stop   = (bit_cnt_q == LAST_STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timer_clear),
        .bit_tick (bit_tick),
        .pre_tick (pre_tick)
    );

    // State and registered-output flops; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tx_q         <= 1'b1;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tx_q         <= tx_d;
            rd_en_q      <= rd_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state: tx_en and fifo_empty are only consulted when deciding to pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (tx_en && !fifo_empty) state_d = ST_POP;
            ST_POP:    state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_START;
            ST_START:  if (bit_tick) state_d = ST_DATA;
            ST_DATA:   if (bit_tick && last_data) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_tick) state_d = ST_STOP;
            ST_STOP:   if (bit_tick && last_stop) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values, each computed one cycle ahead of its flop.
    always_comb begin
        tx_d         = tx_q;
        rd_en_d      = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        shift_d      = shift_q;
        parity_d     = parity_q;
        bit_cnt_d    = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                tx_d      = 1'b1;
                bit_cnt_d = '0;
                if (state_d == ST_POP) begin
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                shift_d   = fifo_data;
                parity_d  = (^fifo_data) ^ (PARITY_ODD != 0);
                tx_d      = 1'b0;
                bit_cnt_d = '0;
            end
            ST_START: begin
                if (bit_tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (last_data) begin
                        bit_cnt_d = '0;
                        tx_d      = (PARITY_EN != 0) ? parity_q : 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) tx_d = 1'b1;
            end
            ST_STOP: begin
                frame_done_d = pre_tick && last_stop;
                if (bit_tick) begin
                    if (last_stop) busy_d = 1'b0;
                    else           bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

    assign tx         = tx_q;
    assign fifo_rd_en = rd_en_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       tx_en0 = 1'b0;
    logic       fifo_empty0;
    logic [7:0] fifo_data0 = 8'h00;
    logic       rd_en0, tx0, busy0, fd0;

    logic       tx_en_p = 1'b1;
    logic       src_empty = 1'b1;
    logic [7:0] src_byte = 8'h00;
    logic [7:0] src_data = 8'h00;
    logic       rd_en1, tx1, busy1, fd1;
    logic       rd_en2, tx2, busy2, fd2;

    logic [7:0] mem [0:255];
    int         wptr = 0;
    int         rptr = 0;
    int         cyc = 0;
    int         rd_cnt = 0;
    int         fd_total = 0;
    int         last_rd_cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;
    vec_t vecs [4];

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty0), .fifo_data(fifo_data0),
        .fifo_rd_en(rd_en0), .tx_en(tx_en0), .tx(tx0), .busy(busy0), .frame_done(fd0));

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(src_empty), .fifo_data(src_data),
        .fifo_rd_en(rd_en1), .tx_en(tx_en_p), .tx(tx1), .busy(busy1), .frame_done(fd1));

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(src_empty), .fifo_data(src_data),
        .fifo_rd_en(rd_en2), .tx_en(tx_en_p), .tx(tx2), .busy(busy2), .frame_done(fd2));

    // FIFO model: data_out is registered, valid the cycle after rd_en.
    assign fifo_empty0 = (wptr == rptr);
    always @(posedge clk) begin
        if (rd_en0 && (wptr != rptr)) begin
            fifo_data0 <= mem[rptr[7:0]];
            rptr <= rptr + 1;
        end
    end

    // Single-byte source shared by the two parity instances.
    always @(posedge clk) begin
        if (rd_en1 || rd_en2) src_data <= src_byte;
    end

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor pop strobes and frame_done pulses of the main instance.
    always @(negedge clk) begin
        if (rd_en0) begin
            rd_cnt <= rd_cnt + 1;
            last_rd_cyc <= cyc;
        end
        if (fd0) fd_total <= fd_total + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wptr[7:0]] = b;
        wptr = wptr + 1;
    endtask

    function automatic logic [2:0] mon(input int w);
        case (w)
            0:       return {tx0, busy0, fd0};
            1:       return {tx1, busy1, fd1};
            default: return {tx2, busy2, fd2};
        endcase
    endfunction

    // Waits (bounded) for a start bit, then samples every cycle of nbits bit periods.
    task automatic rx_frame(input int w, input int nbits, output logic [15:0] bits,
                            output int glitches, output int fd_cnt, output int fd_pos,
                            output int gap, output int fall_cyc, output int busy_low);
        logic [2:0] m;
        bits = '0; glitches = 0; fd_cnt = 0; fd_pos = -1; gap = 0; fall_cyc = 0; busy_low = 0;
        forever begin
            @(negedge clk);
            m = mon(w);
            if (m[2] == 1'b0 || gap >= 400) break;
            gap++;
        end
        if (gap >= 400) return;
        fall_cyc = cyc;
        for (int c = 0; c < nbits * 4; c++) begin
            if (c > 0) @(negedge clk);
            m = mon(w);
            if ((c % 4) == 0) bits[c / 4] = m[2];
            else if (m[2] !== bits[c / 4]) glitches++;
            if (m[1] !== 1'b1) busy_low++;
            if (m[0] === 1'b1) begin
                fd_cnt++;
                fd_pos = c;
            end
        end
    endtask

    initial begin
        logic [15:0] bits, bits2;
        int gl, fdc, fdp, gap, fc, bl;
        int gl2, fdc2, fdp2, gap2, fc2, bl2;
        int rd0, fdb, viol, k;

        vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
        vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
        vecs[3] = '{data: 8'h96, frame: 10'b1100101100};

        // Reset held with a non-empty FIFO.
        push(vecs[0].data);
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || rd_en0 !== 1'b0 || busy0 !== 1'b0 || fd0 !== 1'b0) viol++;
        end
        chk("reset_outputs", viol, 0);
        chk("reset_no_pop", rd_cnt, 0);
        rst_n = 1'b1;
        tx_en0 = 1'b1;

        // Single-frame vectors.
        for (int i = 0; i < 4; i++) begin
            if (i != 0) push(vecs[i].data);
            rd0 = rd_cnt;
            rx_frame(0, 10, bits, gl, fdc, fdp, gap, fc, bl);
            chk("single_timeout", (gap >= 400), 0);
            chk("single_frame", bits[9:0], vecs[i].frame);
            chk("single_bit_width", gl, 0);
            chk("single_fd_count", fdc, 1);
            chk("single_fd_pos", fdp, 39);
            chk("single_latency", fc - last_rd_cyc, 2);
            chk("single_busy", bl, 0);
            chk("single_rd_pulses", rd_cnt - rd0, 1);
            @(negedge clk);
            chk("single_busy_after", busy0, 0);
        end

        // Burst of 16 bytes.
        tx_en0 = 1'b0;
        for (int i = 1; i <= 16; i++) push(8'(i));
        rd0 = rd_cnt;
        tx_en0 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            rx_frame(0, 10, bits, gl, fdc, fdp, gap, fc, bl);
            chk("burst_data", {bits[9], bits[8:1], bits[0]}, {1'b1, 8'(i), 1'b0});
            if (i > 1) chk("burst_gap", gap, 3);
        end
        @(negedge clk);
        chk("burst_rd_pulses", rd_cnt - rd0, 16);
        chk("burst_empty", fifo_empty0, 1);
        chk("burst_busy", busy0, 0);

        // Parity variants on byte 0x07.
        src_byte = 8'h07;
        src_empty = 1'b0;
        k = 0;
        while (rd_en1 !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("parity_pop", rd_en1, 1);
        src_empty = 1'b1;
        fork
            rx_frame(1, 12, bits, gl, fdc, fdp, gap, fc, bl);
            rx_frame(2, 11, bits2, gl2, fdc2, fdp2, gap2, fc2, bl2);
        join
        chk("odd_frame", bits[11:0], 12'b110000001110);
        chk("odd_parity_bit", bits[9], 0);
        chk("odd_bit_width", gl, 0);
        chk("odd_fd_pos_2stop", fdp, 47);
        chk("odd_fd_count", fdc, 1);
        chk("even_frame", bits2[10:0], 11'b11000001110);
        chk("even_parity_bit", bits2[9], 1);
        chk("even_fd_pos", fdp2, 43);
        @(negedge clk);
        chk("parity_busy_after", {busy1, busy2}, 2'b00);

        // Enable gating.
        tx_en0 = 1'b0;
        push(8'h3C);
        push(8'h55);
        rd0 = rd_cnt;
        repeat (100) @(negedge clk);
        chk("gate_no_pop", rd_cnt - rd0, 0);
        fork
            rx_frame(0, 10, bits, gl, fdc, fdp, gap, fc, bl);
            begin
                tx_en0 = 1'b1;
                k = 0;
                while (tx0 !== 1'b0 && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                repeat (10) @(negedge clk);
                tx_en0 = 1'b0;
            end
        join
        chk("gate_frame", bits[9:0], 10'b1001111000);
        chk("gate_fd_count", fdc, 1);
        repeat (40) @(negedge clk);
        chk("gate_one_pop", rd_cnt - rd0, 1);
        chk("gate_queued", fifo_empty0, 0);
        chk("gate_busy", busy0, 0);
        tx_en0 = 1'b1;
        rx_frame(0, 10, bits, gl, fdc, fdp, gap, fc, bl);
        chk("gate_resume_frame", bits[9:0], 10'b1010101010);

        // Reset during data bit 3 of 0x81, then 0x42 must go out intact.
        push(8'h81);
        push(8'h42);
        k = 0;
        while (tx0 !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (17) @(negedge clk);
        chk("midreset_pre_tx", tx0, 0);
        fdb = fd_total;
        rst_n = 1'b0;
        #1;
        chk("midreset_tx", tx0, 1);
        chk("midreset_busy", busy0, 0);
        repeat (3) @(negedge clk);
        chk("midreset_no_fd", fd_total - fdb, 0);
        rst_n = 1'b1;
        rx_frame(0, 10, bits, gl, fdc, fdp, gap, fc, bl);
        chk("midreset_next_frame", bits[9:0], 10'b1010000100);
        chk("midreset_next_fd", fdc, 1);
        @(negedge clk);
        chk("midreset_fd_total", fd_total - fdb, 1);
        chk("final_empty", fifo_empty0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
